// File: rtl/mem_port_arbiter.sv
// Two-port (instruction/data) arbiter onto a single memory bridge port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; default is data-first priority.
module mem_port_arbiter (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_ready,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_sel,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_ready,
   output logic [31:0] mem_a,
   output logic        mem_access,
   output logic        mem_write,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_sel,
   output logic [31:0] mem_st_data,
   input  logic        mem_ready,
   input  logic [31:0] mem_data
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t state;
   logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;  // 1 when the data port held the most recent grant
   always_comb begin
      pick_d = data_req && (!inst_req || !last_d);
   end
`else
   always_comb begin
      pick_d = data_req;
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         mem_access  <= 1'b0;
         mem_write   <= 1'b0;
         mem_a       <= '0;
         mem_size    <= '0;
         mem_sel     <= '0;
         mem_st_data <= '0;
         inst_ready  <= 1'b0;
         data_ready  <= 1'b0;
         inst_rdata  <= '0;
         data_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_d) begin
                  state       <= BUSY_D;
                  mem_access  <= 1'b1;
                  mem_write   <= data_wr;
                  mem_a       <= data_addr;
                  mem_size    <= data_size;
                  mem_sel     <= data_sel;
                  mem_st_data <= data_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                  last_d      <= 1'b1;
`endif
               end else if (inst_req) begin
                  state       <= BUSY_I;
                  mem_access  <= 1'b1;
                  mem_write   <= 1'b0;
                  mem_a       <= inst_addr;
                  mem_size    <= 2'd2;
                  mem_sel     <= 4'hf;
                  mem_st_data <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                  last_d      <= 1'b0;
`endif
               end
            end
            BUSY_I: begin
               if (mem_ready) begin
                  state      <= DONE;
                  mem_access <= 1'b0;
                  inst_rdata <= mem_data;
                  inst_ready <= 1'b1;
               end
            end
            BUSY_D: begin
               if (mem_ready) begin
                  state      <= DONE;
                  mem_access <= 1'b0;
                  data_ready <= 1'b1;
                  // stores leave the last load result visible
                  if (!mem_write) data_rdata <= mem_data;
               end
            end
            default: begin
               // DONE: ready pulse ends; the extra idle cycle keeps the bridge from re-triggering
               state      <= IDLE;
               inst_ready <= 1'b0;
               data_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs driven and outputs sampled on negedge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_ready;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_sel;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        data_ready;
   logic [31:0] mem_a;
   logic        mem_access, mem_write;
   logic [1:0]  mem_size;
   logic [3:0]  mem_sel;
   logic [31:0] mem_st_data;
   logic        mem_ready;
   logic [31:0] mem_data;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_sel(data_sel),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
      .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
      .mem_sel(mem_sel), .mem_st_data(mem_st_data), .mem_ready(mem_ready), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_access"}, {31'd0, mem_access}, 32'd0);
      chk({tag, "_write"},  {31'd0, mem_write},  32'd0);
      chk({tag, "_a"},      mem_a,               32'd0);
      chk({tag, "_size"},   {30'd0, mem_size},   32'd0);
      chk({tag, "_sel"},    {28'd0, mem_sel},    32'd0);
      chk({tag, "_st"},     mem_st_data,         32'd0);
      chk({tag, "_irdy"},   {31'd0, inst_ready}, 32'd0);
      chk({tag, "_drdy"},   {31'd0, data_ready}, 32'd0);
      chk({tag, "_irdata"}, inst_rdata,          32'd0);
      chk({tag, "_drdata"}, data_rdata,          32'd0);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] order, exp_order;
      int         ni, nd, ng, cyc;

      resetn = 1'b0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
      data_size = 0; data_sel = 0; data_addr = 0; data_wdata = 0;
      mem_ready = 0; mem_data = 0;
      step(); step();
      chk_zero("rst");
      resetn = 1'b1;
      step();

      // instruction fetch, bridge answers on the 5th busy cycle
      inst_req = 1; inst_addr = 32'hBFC00004;
      step();
      chk("if_access", {31'd0, mem_access}, 32'd1);
      chk("if_a",      mem_a, 32'hBFC00004);
      chk("if_write",  {31'd0, mem_write}, 32'd0);
      chk("if_size",   {30'd0, mem_size}, 32'd2);
      chk("if_sel",    {28'd0, mem_sel}, 32'hf);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("if_hold", {31'd0, mem_access}, 32'd1);
      end
      mem_ready = 1; mem_data = 32'h3C010001;
      step();
      mem_ready = 0; mem_data = 32'hFFFFFFFF;
      chk("if_irdy",   {31'd0, inst_ready}, 32'd1);
      chk("if_drdy",   {31'd0, data_ready}, 32'd0);
      chk("if_rdata",  inst_rdata, 32'h3C010001);
      chk("if_gap0",   {31'd0, mem_access}, 32'd0);
      inst_req = 0;
      step();
      chk("if_irdy_off", {31'd0, inst_ready}, 32'd0);
      chk("if_gap1",     {31'd0, mem_access}, 32'd0);
      step();
      chk("if_rdata_hold", inst_rdata, 32'h3C010001);

      // spurious completion in IDLE
      mem_ready = 1; mem_data = 32'h55555555;
      step();
      mem_ready = 0;
      chk("sp_irdy",   {31'd0, inst_ready}, 32'd0);
      chk("sp_drdy",   {31'd0, data_ready}, 32'd0);
      chk("sp_access", {31'd0, mem_access}, 32'd0);
      chk("sp_rdata",  inst_rdata, 32'h3C010001);
      step();
      chk("sp_drdy2",  {31'd0, data_ready}, 32'd0);

      // load to give data_rdata a known value
      data_req = 1; data_wr = 0; data_addr = 32'h80000000; data_size = 2; data_sel = 4'hf;
      step();
      chk("ld_a", mem_a, 32'h80000000);
      mem_ready = 1; mem_data = 32'h12345678;
      step();
      mem_ready = 0;
      chk("ld_drdy",  {31'd0, data_ready}, 32'd1);
      chk("ld_rdata", data_rdata, 32'h12345678);
      data_req = 0;
      step(); step();

      // halfword store, fields must hold until mem_ready
      data_req = 1; data_wr = 1; data_addr = 32'h80001000; data_sel = 4'b0011;
      data_size = 1; data_wdata = 32'h0000BEEF;
      step();
      data_addr = 32'h0; data_wdata = 32'h0; data_sel = 4'h0; data_size = 0; data_wr = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("st_access", {31'd0, mem_access}, 32'd1);
         chk("st_write",  {31'd0, mem_write}, 32'd1);
         chk("st_a",      mem_a, 32'h80001000);
         chk("st_sel",    {28'd0, mem_sel}, 32'h3);
         chk("st_size",   {30'd0, mem_size}, 32'd1);
         chk("st_wdata",  mem_st_data, 32'h0000BEEF);
      end
      mem_ready = 1; mem_data = 32'hDEADDEAD;
      step();
      mem_ready = 0;
      chk("st_drdy",  {31'd0, data_ready}, 32'd1);
      chk("st_irdy",  {31'd0, inst_ready}, 32'd0);
      chk("st_rdata", data_rdata, 32'h12345678);
      data_req = 0;
      step(); step();

      // tie: both ports want three transactions each
      inst_addr = 32'h00001000; data_addr = 32'h00002000; data_wr = 0; data_size = 2; data_sel = 4'hf;
      inst_req = 1; data_req = 1; ni = 3; nd = 3; ng = 0; order = '0; cyc = 0;
      while ((ni > 0 || nd > 0) && cyc < 200) begin
         step();
         cyc++;
         if (mem_ready) mem_ready = 0;
         else if (mem_access) begin
            if (ng < 6) order[ng] = (mem_a == 32'h00002000);
            ng++;
            mem_ready = 1; mem_data = 32'hA0000000 + ng;
         end
         if (inst_ready) begin ni--; if (ni == 0) inst_req = 0; end
         if (data_ready) begin nd--; if (nd == 0) data_req = 0; end
      end
      mem_ready = 0;
      chk("tie_timeout", cyc < 200 ? 32'd0 : 32'd1, 32'd0);
      chk("tie_count", ng, 32'd6);
`ifdef ARB_ROUND_ROBIN_EN
      exp_order = 6'b010101;
`else
      exp_order = 6'b000111;
`endif
      for (int k = 0; k < 6; k++)
         chk($sformatf("tie_grant%0d", k), {31'd0, order[k]}, {31'd0, exp_order[k]});
      step(); step();

      // reset in the middle of a data transaction
      data_req = 1; data_wr = 0; data_addr = 32'h80002000;
      step();
      chk("rb_access", {31'd0, mem_access}, 32'd1);
      resetn = 0;
      step();
      chk_zero("rmid");
      data_req = 0; resetn = 1;
      inst_req = 1; inst_addr = 32'hBFC00000;
      step();
      chk("ra_access", {31'd0, mem_access}, 32'd1);
      chk("ra_a",      mem_a, 32'hBFC00000);
      mem_ready = 1; mem_data = 32'h24080001;
      step();
      mem_ready = 0;
      chk("ra_irdy",  {31'd0, inst_ready}, 32'd1);
      chk("ra_rdata", inst_rdata, 32'h24080001);
      inst_req = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have these instruction-port signals:
- inst_req, input, 1, fetch request, held until inst_ready.
- inst_addr, input, 32, fetch address.
- inst_rdata, output, 32, fetch data.
- inst_ready, output, 1, one-cycle completion pulse.
REQ-004 SHALL have these data-port signals:
- data_req, input, 1, load/store request, held until data_ready.
- data_wr, input, 1, 1 = store.
- data_size, input, 2, log2 of access bytes.
- data_sel, input, 4, byte strobes.
- data_addr, input, 32, address.
- data_wdata, input, 32, store data.
- data_rdata, output, 32, load data.
- data_ready, output, 1, one-cycle completion pulse.
REQ-005 SHALL have these memory-side signals, feeding the AXI bridge:
- mem_a, output, 32, address.
- mem_access, output, 1, request valid.
- mem_write, output, 1, 1 = write.
- mem_size, output, 2, size.
- mem_sel, output, 4, strobes.
- mem_st_data, output, 32, store data.
- mem_ready, input, 1, single-cycle completion.
- mem_data, input, 32, read data, valid only when mem_ready = 1.

Function
REQ-006 SHALL implement states IDLE, BUSY_I, BUSY_D, DONE; all mem_* outputs SHALL be registered.
REQ-007 In IDLE with data_req = 1, the block SHALL go to BUSY_D and latch data_addr, data_wr, data_size, data_sel and data_wdata onto mem_*; with only inst_req = 1, it SHALL go to BUSY_I with mem_write = 0, mem_size = 2, mem_sel = 4'hf, mem_a = inst_addr.
REQ-008 In BUSY_I/BUSY_D, mem_access SHALL be 1 and mem_a, mem_write, mem_size, mem_sel and mem_st_data SHALL be held constant until the cycle mem_ready = 1.
REQ-009 On mem_ready = 1 in BUSY_I, the block SHALL capture mem_data into inst_rdata, deassert mem_access, and enter DONE.
REQ-010 On mem_ready = 1 in BUSY_D, the block SHALL behave as REQ-009, capturing mem_data into data_rdata only when mem_write = 0; data_rdata SHALL hold its previous value on a store.
REQ-011 In DONE, the block SHALL assert exactly one of inst_ready/data_ready for one cycle, keep mem_access = 0, and return to IDLE.
- Minimum gap between memory requests: two cycles with mem_access = 0 (DONE, IDLE).
- This gap prevents the downstream bridge re-triggering.
REQ-012 Latency from request sampled in IDLE (edge N) to mem_access = 1 SHALL be 1 cycle; ready SHALL be asserted the cycle after mem_ready.
REQ-013 inst_rdata/data_rdata SHALL remain stable from their ready pulse until the next completion on the same port.
REQ-014 mem_ready received in IDLE or DONE SHALL be ignored.
REQ-015 Requests arriving while not in IDLE SHALL wait; requesters SHALL NOT be dropped, and a held request SHALL be granted in a later IDLE.
REQ-016 A request deasserted in the same cycle as its ready pulse SHALL NOT be re-issued.

Reset
REQ-017 While resetn = 0, the block SHALL force state IDLE and clear these outputs to 0:
- mem_access, mem_write, mem_a, mem_size, mem_sel, mem_st_data
- inst_ready, data_ready, inst_rdata, data_rdata
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction; after release, the first request SHALL be arbitrated from IDLE.

Configuration
REQ-019 With ARB_ROUND_ROBIN_EN defined, when both requests are pending in IDLE the block SHALL grant the port not granted last; the last-grant register SHALL reset to "instruction", so data wins the first tie.
REQ-020 Without ARB_ROUND_ROBIN_EN, the data port SHALL always win simultaneous requests (fixed priority, REQ-007).

Verification
REQ-021 Reset: resetn = 0 mid-BUSY_D -> next cycle mem_access = 0, all outputs 0; after release, inst_req at addr 0xBFC00000 -> mem_access = 1 one cycle later with mem_a = 0xBFC00000.
REQ-022 Instruction fetch: inst_req, addr 0xBFC00004; bridge returns mem_ready with mem_data = 0x3C010001 after 5 cycles -> inst_rdata = 0x3C010001, inst_ready pulse exactly one cycle later, mem_access low 2 cycles.
REQ-023 Store: data_req, data_wr = 1, addr 0x80001000, data_sel = 4'b0011, data_size = 1, wdata 0x0000BEEF -> mem_* carry these values unchanged until mem_ready; data_ready pulses; data_rdata unchanged.
REQ-024 Tie, no macro: inst_req and data_req asserted together for 3 transactions each -> the order SHALL be D, D, D, I, I, I.
REQ-025 Tie, ARB_ROUND_ROBIN_EN: the same stimulus as REQ-024 -> the order SHALL be D, I, D, I, D, I.
REQ-026 Spurious completion: mem_ready pulse in IDLE -> no ready outputs asserted, no state change.
